// File: rtl/breadboard_pkg.sv
// ----------------------------------------------------------------------------
// breadboard_pkg: FSM states, response bit layout and golden model of the block
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package breadboard_pkg;

  localparam int RESP_W = 4;
  localparam int R2_BIT = 3;
  localparam int R3_BIT = 2;
  localparam int R4_BIT = 1;
  localparam int R7_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EMIT   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // v = {w,x,y,z}; result packed as {r2,r3,r4,r7}
  function automatic logic [RESP_W-1:0] golden_resp(input logic [3:0] v);
    logic [2:0]        pop;
    logic [RESP_W-1:0] r;
    pop = {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
    r = '0;
    r[R2_BIT] = (pop >= 3'd3);
    r[R3_BIT] = (v[3] & v[0]) | (v[2] & v[1]);
    r[R4_BIT] = v[1] & v[0];
    r[R7_BIT] = (pop == 3'd2);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/breadboard_golden.sv
// ----------------------------------------------------------------------------
// breadboard_golden: combinational expected response for one input vector
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module breadboard_golden
  import breadboard_pkg::*;
(
  input  logic [3:0]        i_vec,
  output logic [RESP_W-1:0] o_resp
);

  assign o_resp = golden_resp(i_vec);

endmodule

`default_nettype wire

// File: rtl/breadboard_scanner.sv
// ----------------------------------------------------------------------------
// breadboard_scanner: sweeps vectors 0..15 into the breadboard, samples and
// checks the responses, streams per-vector results over valid/ready.
// Option: define BREADBOARD_SCANNER_SYNC_EN to add a 2-flop input synchronizer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module breadboard_scanner
  import breadboard_pkg::*;
#(
  parameter int          SETTLE_CYC  = 4,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              drv_w,
  output logic              drv_x,
  output logic              drv_y,
  output logic              drv_z,
  input  logic              smp_r2,
  input  logic              smp_r3,
  input  logic              smp_r4,
  input  logic              smp_r7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_idx,
  output logic [RESP_W-1:0] out_resp,
  output logic [RESP_W-1:0] out_exp,
  output logic              out_mismatch,
  output logic [4:0]        err_count,
  output logic              pass
);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_idx;
  logic [7:0]        r_cnt;
  logic [3:0]        r_drv;
  logic [RESP_W-1:0] r_resp;
  logic [RESP_W-1:0] r_exp;
  logic              r_mism;
  logic [4:0]        r_err;
  logic              r_pass;
  logic [RESP_W-1:0] w_smp_raw;
  logic [RESP_W-1:0] w_smp;
  logic [RESP_W-1:0] w_exp;
  logic              w_hs;
  logic              w_last;
  logic [4:0]        w_err_nxt;

  always_comb begin
    w_smp_raw         = '0;
    w_smp_raw[R2_BIT] = smp_r2;
    w_smp_raw[R3_BIT] = smp_r3;
    w_smp_raw[R4_BIT] = smp_r4;
    w_smp_raw[R7_BIT] = smp_r7;
  end

`ifdef BREADBOARD_SCANNER_SYNC_EN
  logic [RESP_W-1:0] r_sync1;
  logic [RESP_W-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_smp_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_smp = r_sync2;
`else
  assign w_smp = w_smp_raw;
`endif

  breadboard_golden u_golden (
    .i_vec  (r_idx),
    .o_resp (w_exp)
  );

  assign w_hs      = (r_state == ST_EMIT) && out_ready;
  assign w_last    = (r_idx == 4'd15) || ((STOP_ON_ERR != 0) && r_mism);
  assign w_err_nxt = r_err + {4'd0, r_mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_DRIVE;
      ST_DRIVE:  w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == 8'd0) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = ST_EMIT;
      ST_EMIT:   if (w_hs) w_next = w_last ? ST_FINISH : ST_DRIVE;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_DRIVE, ST_SETTLE, ST_SAMPLE: busy = 1'b1;
      ST_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Pass is captured on the final handshake so it is already valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_drv  <= '0;
      r_resp <= '0;
      r_exp  <= '0;
      r_mism <= 1'b0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_err  <= '0;
          r_pass <= 1'b0;
          r_idx  <= '0;
        end
        ST_DRIVE: begin
          r_drv <= r_idx;
          r_cnt <= 8'(SETTLE_CYC - 1);
        end
        ST_SETTLE: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        ST_SAMPLE: begin
          r_resp <= w_smp;
          r_exp  <= w_exp;
          r_mism <= (w_smp != w_exp);
        end
        ST_EMIT: if (w_hs) begin
          r_err <= w_err_nxt;
          if (w_last) r_pass <= (w_err_nxt == 5'd0) && (r_idx == 4'd15);
          else        r_idx  <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign {drv_w, drv_x, drv_y, drv_z} = r_drv;
  assign out_idx      = r_idx;
  assign out_resp     = r_resp;
  assign out_exp      = r_exp;
  assign out_mismatch = r_mism;
  assign err_count    = r_err;
  assign pass         = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_breadboard_scanner.sv
// ----------------------------------------------------------------------------
// tb_breadboard_scanner: directed checks of breadboard_scanner against a stub board
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_breadboard_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic ready = 1'b1;
  logic stuck = 1'b0;
  logic sel = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Hand-derived {r2,r3,r4,r7} for vectors 0..15
  function automatic logic [3:0] tbl(input int v);
    case (v)
      3:       return 4'h3;
      5, 10, 12: return 4'h1;
      6, 9:    return 4'h5;
      7, 11, 15: return 4'hE;
      13, 14:  return 4'hC;
      default: return 4'h0;
    endcase
  endfunction

  wire       busy_a, done_a, valid_a, mism_a, pass_a;
  wire       busy_b, done_b, valid_b, mism_b, pass_b;
  wire [3:0] drv_a, idx_a, resp_a, exp_a, smp_a;
  wire [3:0] drv_b, idx_b, resp_b, exp_b, smp_b;
  wire [4:0] err_a, err_b;

  assign smp_a = tbl(int'(drv_a)) & (stuck ? 4'b1101 : 4'b1111);
  assign smp_b = tbl(int'(drv_b)) & 4'b1101;

  breadboard_scanner #(.SETTLE_CYC(4), .STOP_ON_ERR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .drv_w(drv_a[3]), .drv_x(drv_a[2]), .drv_y(drv_a[1]), .drv_z(drv_a[0]),
    .smp_r2(smp_a[3]), .smp_r3(smp_a[2]), .smp_r4(smp_a[1]), .smp_r7(smp_a[0]),
    .out_valid(valid_a), .out_ready(ready), .out_idx(idx_a), .out_resp(resp_a),
    .out_exp(exp_a), .out_mismatch(mism_a), .err_count(err_a), .pass(pass_a)
  );

  breadboard_scanner #(.SETTLE_CYC(4), .STOP_ON_ERR(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .drv_w(drv_b[3]), .drv_x(drv_b[2]), .drv_y(drv_b[1]), .drv_z(drv_b[0]),
    .smp_r2(smp_b[3]), .smp_r3(smp_b[2]), .smp_r4(smp_b[1]), .smp_r7(smp_b[0]),
    .out_valid(valid_b), .out_ready(ready), .out_idx(idx_b), .out_resp(resp_b),
    .out_exp(exp_b), .out_mismatch(mism_b), .err_count(err_b), .pass(pass_b)
  );

  wire [25:0] all_a = {busy_a, done_a, drv_a, valid_a, idx_a, resp_a, exp_a, mism_a, err_a, pass_a};
  wire [25:0] all_b = {busy_b, done_b, drv_b, valid_b, idx_b, resp_b, exp_b, mism_b, err_b, pass_b};

  wire        o_busy  = sel ? busy_b  : busy_a;
  wire        o_done  = sel ? done_b  : done_a;
  wire        o_valid = sel ? valid_b : valid_a;
  wire        o_mism  = sel ? mism_b  : mism_a;
  wire        o_pass  = sel ? pass_b  : pass_a;
  wire [3:0]  o_drv   = sel ? drv_b   : drv_a;
  wire [3:0]  o_idx   = sel ? idx_b   : idx_a;
  wire [3:0]  o_resp  = sel ? resp_b  : resp_a;
  wire [3:0]  o_exp   = sel ? exp_b   : exp_a;
  wire [4:0]  o_err   = sel ? err_b   : err_a;
  wire [25:0] o_all   = sel ? all_b   : all_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sweep(input bit s, input bit stk, input int stall_idx, input int poke_idx,
                       input int rst_idx, input int exp_beats, input int exp_cyc,
                       input int exp_errs, input bit exp_pass);
    int  cyc, beats, stall_left, run_err;
    bit  got_done, aborted;
    logic [3:0] rexp;
    sel = s; stuck = stk; ready = 1'b1;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    cyc = 0; beats = 0; stall_left = 5; run_err = 0; got_done = 0; aborted = 0;
    while (!got_done && !aborted && cyc < 400) begin
      start_a = 1'b0; start_b = 1'b0;
      if (o_done) begin
        got_done = 1;
      end else begin
        if (rst_idx >= 0 && o_busy && !o_valid && int'(o_drv) == rst_idx) begin
          #1 rst_n = 1'b0;
          #1 check("async_rst_outs", o_all, 26'd0);
          @(negedge clk);
          check("rst_no_done", {31'd0, o_done}, 32'd0);
          check("rst_hold_outs", o_all, 26'd0);
          rst_n = 1'b1;
          aborted = 1;
        end else if (o_valid) begin
          if (int'(o_idx) == stall_idx && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
            check("stall_idx", o_idx, stall_idx);
            check("stall_resp", o_resp, tbl(stall_idx));
            check("stall_drv", o_drv, stall_idx);
          end else begin
            ready = 1'b1;
            rexp = tbl(beats) & (stk ? 4'b1101 : 4'b1111);
            check("beat_idx", o_idx, beats);
            check("beat_drv", o_drv, beats);
            check("beat_exp", o_exp, tbl(beats));
            check("beat_resp", o_resp, rexp);
            check("beat_mism", {31'd0, o_mism}, {31'd0, rexp != tbl(beats)});
            check("beat_err_run", o_err, run_err);
            if (rexp != tbl(beats)) run_err++;
            if (beats == poke_idx) begin
              check("poke_busy", {31'd0, o_busy}, 32'd1);
              if (s) start_b = 1'b1; else start_a = 1'b1;
            end
            beats++;
          end
        end
        if (!aborted) begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
    if (!aborted) begin
      check("done_seen", {31'd0, got_done}, 32'd1);
      check("done_latency", cyc, exp_cyc);
      check("beat_count", beats, exp_beats);
      check("err_count", o_err, exp_errs);
      check("pass", {31'd0, o_pass}, {31'd0, exp_pass});
      check("busy_at_done", {31'd0, o_busy}, 32'd0);
      check("drv_hold_last", o_drv, exp_beats - 1);
      @(negedge clk);
      check("done_one_cycle", {31'd0, o_done}, 32'd0);
      check("pass_hold", {31'd0, o_pass}, {31'd0, exp_pass});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs_a", all_a, 26'd0);
    check("reset_outs_b", all_b, 26'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // clean sweep
    sweep(1'b0, 1'b0, -1, -1, -1, 16, 112, 0, 1'b1);
    // r4 stuck at 0: mismatches at 3, 7, 11, 15
    sweep(1'b0, 1'b1, -1, -1, -1, 16, 112, 4, 1'b0);
    // r4 stuck at 0 with stop-on-error: ends after beat 3
    sweep(1'b1, 1'b1, -1, -1, -1, 4, 28, 1, 1'b0);
    // host backpressure for 5 cycles on vector 6
    sweep(1'b0, 1'b0, 6, -1, -1, 16, 117, 0, 1'b1);
    // start pulse while busy is ignored
    sweep(1'b0, 1'b0, -1, 5, -1, 16, 112, 0, 1'b1);
    // asynchronous reset during settle of vector 9, then a fresh sweep
    sweep(1'b0, 1'b0, -1, -1, 9, 16, 112, 0, 1'b1);
    sweep(1'b0, 1'b0, -1, -1, -1, 16, 112, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
